msrv32_lsu_ctrl: RTL and testbench
==================================

# msrv32_lsu_ctrl

Load/store control stage of the MSRV32 core, directly downstream of `msrv32_reg_block2`. It takes that block's registered address (`iadder`), store data (`rs2`), `load_size` and `load_unsigned` and runs a req/ack transaction on the data bus. It returns aligned, sign- or zero-extended load data to the writeback mux and holds `stall_out` high while a transaction is outstanding. It also detects misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 16: WAIT-state cycles without ack before the transaction is aborted (≥2).
- clk_in  in  1  core clock, rising edge.
- reset_in  in  1  active-low, synchronous.
- mem_rd_req_in  in  1  load request; sampled in IDLE only.
- mem_wr_req_in  in  1  store request; sampled in IDLE only; has priority over read.
- iadder_in  in  32  byte address.
- rs2_in  in  32  store data.
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  in  1  1 = zero-extend, 0 = sign-extend.
- dbus_ack_in  in  1  bus completion; honoured only in WAIT.
- dbus_rdata_in  in  32  read data; valid with ack.
- dbus_addr_out  out  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_wdata_out  out  32  lane-replicated store data.
- dbus_wr_mask_out  out  4  byte enables (stores only, else 0).
- dbus_rd_req_out / dbus_wr_req_out  out  1 each  bus request, held until ack or timeout.
- lu_output_out  out  32  extended load result; holds until the next load completes.
- load_valid_out  out  1  one-cycle pulse, result valid.
- stall_out  out  1  combinational pipeline stall.
- misaligned_load_out / misaligned_store_out  out  1 each  one-cycle pulse.
- bus_error_out  out  1  one-cycle timeout pulse.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - A request is accepted if it is aligned. Half needs addr[0]=0. Word needs addr[1:0]=0. Byte is always aligned.
  - On an accepted request, register the bus address, mask, data and request bits, latch addr[1:0], size and unsigned, clear the timeout counter, and go to WAIT.
  - A misaligned request produces no bus access. The matching misaligned pulse appears next cycle and the FSM stays in IDLE.
  - If rd and wr are both high, it is a store; the read is dropped.
- **WAIT**
  - Request outputs stay stable.
  - On ack:
    - Drop the requests.
    - For a load, extract the lane by the latched addr[1:0]. Byte uses [8a+7:8a]. Half uses [15:0] when addr[1]=0, otherwise [31:16].
    - Extend the lane and register it into lu_output_out.
    - Go to DONE.
  - With no ack and counter = TIMEOUT_CYCLES-1: drop the requests, pulse bus_error_out, go to IDLE, and leave lu_output_out unchanged.
  - Otherwise increment the counter.
- **DONE**
  - load_valid_out = 1 for loads only; stores give no pulse.
  - Unconditionally go to IDLE.
- **Store lanes**
  - Byte: mask = 1<<addr[1:0], data = {4{rs2[7:0]}}.
  - Half: mask 0011 or 1100, data = {2{rs2[15:0]}}.
  - Word: mask 1111, data = rs2.
- **stall_out** = (IDLE & accepted request) | WAIT.
- **Reset**
  - FSM to IDLE, counter 0, every output 0 including lu_output_out.
  - Reset during WAIT abandons the transaction: the requests are low after that edge and no pulse is issued.

## Timing
- Request in cycle T (IDLE): stall_out high in T. dbus_*_req_out high from T+1.
- Zero-wait ack sampled at edge end of T+1: DONE in T+2. lu_output_out and load_valid_out valid in T+2, stall_out low in T+2. Load-to-use latency is 2 cycles.
- Each extra wait cycle adds one cycle.
- Timeout: requests high for exactly TIMEOUT_CYCLES cycles. bus_error_out is high in the cycle after the last one.
- An ack arriving in the same cycle as the timeout count wins: it completes normally.
- A new request can be accepted in the cycle after DONE, giving back-to-back accesses every 3 cycles at zero wait.
- Acks in IDLE or DONE are ignored.

## Structure
- Shared `msrv32_pkg`: the load_size encodings (LS_BYTE/LS_HALF/LS_WORD) and the lsu state enum.
- Sub-module `msrv32_load_align` is purely combinational (rdata, addr[1:0], size, unsigned → 32-bit result). It is instantiated once and is reusable elsewhere.

## Test plan
- **Load byte, zero wait:** addr 0x103, LB signed, rdata 0x80AA_BB11, ack in T+1 → lu_output 0xFFFF_FF80 and load_valid in T+2. stall high T..T+1, dbus_addr 0x100.
- **Store half:** addr 0x202, rs2 0x1234_5678, ack after 3 waits → mask 1100, wdata 0x5678_5678, requests held 4 cycles, no load_valid.
- **Misaligned:** LW at 0x101 → misaligned_load_out pulse, no dbus request. SH at 0x3 → misaligned_store_out pulse.
- **Timeout:** LHU at 0x0 with no ack and TIMEOUT_CYCLES=16 → rd_req high 16 cycles, bus_error pulse, lu_output unchanged. Ack on the 16th cycle → normal completion.
- **Priority and stray ack:** rd+wr together → store only. Ack in IDLE → no effect.
- **Reset in WAIT:** reset_in low in 2nd wait cycle → all outputs 0 next cycle, FSM in IDLE, a later request proceeds normally.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared MSRV32 definitions: load/store size encodings, LSU state enum and
// the alignment rule used by the load/store control stage.
package msrv32_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

  // Byte is always aligned, half needs addr[0]=0, word (and 11) needs addr[1:0]=0.
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      LS_BYTE: addr_aligned = 1'b1;
      LS_HALF: addr_aligned = ~addr_lo[0];
      default: addr_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational load aligner: picks the byte/half lane addressed by
// addr[1:0] out of a bus word and sign- or zero-extends it to 32 bits.
import msrv32_pkg::*;

module msrv32_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension; size 11 falls through to a full word.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    result    = rdata;
    case (addr_lo)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LS_BYTE: result = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      LS_HALF: result = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store control stage: runs one req/ack data-bus transaction per
// accepted request, aligns load data, flags misaligned accesses and aborts
// transactions that see no ack within TIMEOUT_CYCLES wait cycles.
//
// Handshake: a request is taken from the core only in IDLE, in the same
// cycle it is presented (stall_out is high that cycle). The bus request is
// then held stable until the first cycle dbus_ack_in is high while waiting;
// that cycle completes the transfer. Acks seen at any other time are ignored.
import msrv32_pkg::*;

module msrv32_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        dbus_ack_in,
  input  logic [31:0] dbus_rdata_in,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wr_mask_out,
  output logic        dbus_rd_req_out,
  output logic        dbus_wr_req_out,
  output logic [31:0] lu_output_out,
  output logic        load_valid_out,
  output logic        stall_out,
  output logic        misaligned_load_out,
  output logic        misaligned_store_out,
  output logic        bus_error_out,
  output lsu_state_t  lsu_state_out
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        store_q;

  logic        any_req;
  logic        aligned;
  logic        accept;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_result;

  assign lsu_state_out = state;

  // Request decode, store lane placement and the pipeline stall.
  always_comb begin
    any_req = mem_rd_req_in | mem_wr_req_in;
    aligned = addr_aligned(load_size_in, iadder_in[1:0]);
    accept  = (state == ST_IDLE) & any_req & aligned;
    stall_out = accept | (state == ST_WAIT);
    st_mask = 4'b0000;
    st_data = rs2_in;
    case (load_size_in)
      LS_BYTE: begin
        st_mask = 4'b0001 << iadder_in[1:0];
        st_data = {4{rs2_in[7:0]}};
      end
      LS_HALF: begin
        st_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_in[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = rs2_in;
      end
    endcase
  end

  msrv32_load_align u_load_align (
    .rdata       (dbus_rdata_in),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (ld_result)
  );

  // Transaction FSM with registered bus outputs and one-cycle status pulses.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      addr_lo_q            <= 2'b00;
      size_q               <= 2'b00;
      unsigned_q           <= 1'b0;
      store_q              <= 1'b0;
      dbus_addr_out        <= 32'h0;
      dbus_wdata_out       <= 32'h0;
      dbus_wr_mask_out     <= 4'h0;
      dbus_rd_req_out      <= 1'b0;
      dbus_wr_req_out      <= 1'b0;
      lu_output_out        <= 32'h0;
      load_valid_out       <= 1'b0;
      misaligned_load_out  <= 1'b0;
      misaligned_store_out <= 1'b0;
      bus_error_out        <= 1'b0;
    end else begin
      load_valid_out       <= 1'b0;
      misaligned_load_out  <= 1'b0;
      misaligned_store_out <= 1'b0;
      bus_error_out        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (aligned) begin
              dbus_addr_out   <= {iadder_in[31:2], 2'b00};
              dbus_wdata_out  <= st_data;
              // A store wins when both requests are raised together.
              dbus_wr_mask_out <= mem_wr_req_in ? st_mask : 4'b0000;
              dbus_wr_req_out <= mem_wr_req_in;
              dbus_rd_req_out <= ~mem_wr_req_in;
              store_q         <= mem_wr_req_in;
              addr_lo_q       <= iadder_in[1:0];
              size_q          <= load_size_in;
              unsigned_q      <= load_unsigned_in;
              cnt             <= '0;
              state           <= ST_WAIT;
            end else if (mem_wr_req_in) begin
              misaligned_store_out <= 1'b1;
            end else begin
              misaligned_load_out <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (dbus_ack_in) begin
            dbus_rd_req_out <= 1'b0;
            dbus_wr_req_out <= 1'b0;
            if (!store_q) begin
              lu_output_out  <= ld_result;
              load_valid_out <= 1'b1;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dbus_rd_req_out <= 1'b0;
            dbus_wr_req_out <= 1'b0;
            bus_error_out   <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Self-checking bench for msrv32_lsu_ctrl: directed scenarios plus a random
// mix of loads/stores; load results go through an expected-value queue.
import msrv32_pkg::*;

module tb_msrv32_lsu_ctrl;

  localparam int TO = 16;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        mem_rd_req_in;
  logic        mem_wr_req_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wr_mask_out;
  logic        dbus_rd_req_out;
  logic        dbus_wr_req_out;
  logic [31:0] lu_output_out;
  logic        load_valid_out;
  logic        stall_out;
  logic        misaligned_load_out;
  logic        misaligned_store_out;
  logic        bus_error_out;
  lsu_state_t  lsu_state_out;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_lu = 32'h0;

  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .mem_rd_req_in        (mem_rd_req_in),
    .mem_wr_req_in        (mem_wr_req_in),
    .iadder_in            (iadder_in),
    .rs2_in               (rs2_in),
    .load_size_in         (load_size_in),
    .load_unsigned_in     (load_unsigned_in),
    .dbus_ack_in          (dbus_ack_in),
    .dbus_rdata_in        (dbus_rdata_in),
    .dbus_addr_out        (dbus_addr_out),
    .dbus_wdata_out       (dbus_wdata_out),
    .dbus_wr_mask_out     (dbus_wr_mask_out),
    .dbus_rd_req_out      (dbus_rd_req_out),
    .dbus_wr_req_out      (dbus_wr_req_out),
    .lu_output_out        (lu_output_out),
    .load_valid_out       (load_valid_out),
    .stall_out            (stall_out),
    .misaligned_load_out  (misaligned_load_out),
    .misaligned_store_out (misaligned_store_out),
    .bus_error_out        (bus_error_out),
    .lsu_state_out        (lsu_state_out)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every load_valid pulse consumes one expected load result
  always @(negedge clk_in) begin
    if (reset_in === 1'b1 && load_valid_out === 1'b1) begin
      if (exp_q.size() == 0) check("lv_spurious", 32'd1, 32'd0);
      else check("lu_sb", lu_output_out, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    if (sz == LS_BYTE) begin
      sh = rd >> (8 * a);
      return uns ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
    end else if (sz == LS_HALF) begin
      sh = rd >> (16 * a[1]);
      return uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
    end
    return rd;
  endfunction

  task automatic idle_inputs();
    mem_rd_req_in = 1'b0;
    mem_wr_req_in = 1'b0;
    dbus_ack_in   = 1'b0;
  endtask

  // Drive one request; waits >= TO means the bus never acks.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                            input int waits, input logic [31:0] rdata);
    logic al, timeout, is_store;
    logic [3:0] e_mask;
    logic [31:0] e_wdata;
    int cycles;
    is_store = wr;
    timeout  = (waits >= TO);
    cycles   = timeout ? TO : waits + 1;
    al = (sz == LS_BYTE) ? 1'b1 : (sz == LS_HALF) ? ~addr[0] : (addr[1:0] == 2'b00);
    case (sz)
      LS_BYTE: begin e_mask = 4'b0001 << addr[1:0]; e_wdata = {4{wdata[7:0]}}; end
      LS_HALF: begin e_mask = addr[1] ? 4'b1100 : 4'b0011; e_wdata = {2{wdata[15:0]}}; end
      default: begin e_mask = 4'b1111; e_wdata = wdata; end
    endcase

    @(negedge clk_in);
    mem_wr_req_in = wr; mem_rd_req_in = rd; iadder_in = addr; rs2_in = wdata;
    load_size_in = sz; load_unsigned_in = uns; dbus_ack_in = 1'b0;
    #1;
    check("stall_req", stall_out, al);

    if (!al) begin
      @(negedge clk_in);
      idle_inputs();
      #1;
      check("mis_store", misaligned_store_out, is_store);
      check("mis_load", misaligned_load_out, !is_store);
      check("mis_no_req", {dbus_rd_req_out, dbus_wr_req_out}, 2'b00);
      check("mis_state", lsu_state_out, ST_IDLE);
      @(negedge clk_in);
      check("mis_clear", {misaligned_store_out, misaligned_load_out}, 2'b00);
      return;
    end

    if (!is_store && !timeout) begin
      last_lu = model_load(rdata, addr[1:0], sz, uns);
      exp_q.push_back(last_lu);
    end

    for (int w = 0; w < cycles; w++) begin
      @(negedge clk_in);
      mem_rd_req_in = 1'b0; mem_wr_req_in = 1'b0;
      dbus_ack_in   = (!timeout && w == waits);
      dbus_rdata_in = dbus_ack_in ? rdata : $urandom;
      #1;
      check("rd_req", dbus_rd_req_out, !is_store);
      check("wr_req", dbus_wr_req_out, is_store);
      check("bus_addr", dbus_addr_out, {addr[31:2], 2'b00});
      check("wr_mask", dbus_wr_mask_out, is_store ? e_mask : 4'b0000);
      if (is_store) check("wdata", dbus_wdata_out, e_wdata);
      check("stall_wait", stall_out, 1'b1);
    end

    @(negedge clk_in);
    dbus_ack_in = 1'b0;
    #1;
    check("req_drop", {dbus_rd_req_out, dbus_wr_req_out}, 2'b00);
    check("stall_end", stall_out, 1'b0);
    check("lu_hold", lu_output_out, last_lu);
    if (timeout) begin
      check("bus_err", bus_error_out, 1'b1);
      check("to_state", lsu_state_out, ST_IDLE);
      check("to_no_lv", load_valid_out, 1'b0);
      @(negedge clk_in);
      check("bus_err_pulse", bus_error_out, 1'b0);
    end else begin
      check("done_state", lsu_state_out, ST_DONE);
      check("load_valid", load_valid_out, !is_store);
      check("no_bus_err", bus_error_out, 1'b0);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    iadder_in = 32'h0; rs2_in = 32'h0; load_size_in = 2'b00; load_unsigned_in = 1'b0;
    dbus_rdata_in = 32'h0;
    idle_inputs();
    repeat (3) @(negedge clk_in);
    check("rst_state", lsu_state_out, ST_IDLE);
    check("rst_lu", lu_output_out, 32'h0);
    check("rst_reqs", {dbus_rd_req_out, dbus_wr_req_out, load_valid_out, bus_error_out}, 4'h0);
    check("rst_bus", dbus_addr_out | dbus_wdata_out | {28'h0, dbus_wr_mask_out}, 32'h0);
    reset_in = 1'b1;

    // LB signed, zero wait
    run_access(1'b0, 1'b1, 32'h103, 32'h0, LS_BYTE, 1'b0, 0, 32'h80AA_BB11);
    // SH at 0x202, three wait cycles
    run_access(1'b1, 1'b0, 32'h202, 32'h1234_5678, LS_HALF, 1'b0, 3, 32'h0);
    // misaligned LW and SH
    run_access(1'b0, 1'b1, 32'h101, 32'h0, LS_WORD, 1'b0, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h3, 32'hCAFE, LS_HALF, 1'b0, 0, 32'h0);
    // LHU timeout, then ack on the last allowed cycle
    run_access(1'b0, 1'b1, 32'h0, 32'h0, LS_HALF, 1'b1, TO, 32'h0);
    run_access(1'b0, 1'b1, 32'h0, 32'h0, LS_HALF, 1'b1, TO - 1, 32'hBEEF_8001);
    // rd+wr together is a store
    run_access(1'b1, 1'b1, 32'h5, 32'h0000_00A5, LS_BYTE, 1'b0, 1, 32'h0);

    // stray ack in IDLE
    @(negedge clk_in);
    dbus_ack_in = 1'b1; dbus_rdata_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    dbus_ack_in = 1'b0;
    check("stray_state", lsu_state_out, ST_IDLE);
    check("stray_lv", load_valid_out, 1'b0);
    check("stray_lu", lu_output_out, last_lu);

    // reset asserted in the second wait cycle
    @(negedge clk_in);
    mem_rd_req_in = 1'b1; iadder_in = 32'h40; load_size_in = LS_WORD;
    @(negedge clk_in);
    mem_rd_req_in = 1'b0;
    check("rw_req1", dbus_rd_req_out, 1'b1);
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b1;
    last_lu = 32'h0;
    check("rw_state", lsu_state_out, ST_IDLE);
    check("rw_reqs", {dbus_rd_req_out, dbus_wr_req_out, load_valid_out, bus_error_out}, 4'h0);
    check("rw_lu", lu_output_out, 32'h0);
    check("rw_addr", dbus_addr_out, 32'h0);
    @(negedge clk_in);
    check("rw_no_pulse", {load_valid_out, bus_error_out}, 2'b00);
    run_access(1'b0, 1'b1, 32'h44, 32'h0, LS_WORD, 1'b0, 0, 32'h1357_9BDF);

    // random mix, back-to-back
    for (int i = 0; i < 30; i++) begin
      logic wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      run_access(wr, rd, {$urandom_range(0, 32'hFFFF), 2'($urandom_range(0, 3))}, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom);
    end

    repeat (2) @(negedge clk_in);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
